truth_table_scanner: RTL and testbench

Sequencer that exhaustively drives a 3-input combinational circuit under test (inputs A, B, C; output Z) through all 8 input vectors in ascending order. It captures Z for each vector into a truth-table register and compares the table against a parameterised golden value. It reports pass/fail and the lowest mismatching vector index. It sits between a lab-board start button or control FSM and the combinational circuit, replacing hand-written stimulus sequences.

---
 rtl/truth_table_scanner_if.sv | 31 +++
 rtl/truth_table_scanner.sv | 141 ++++++++++++++
 tb/tb_truth_table_scanner.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_scanner_if.sv
// Handshake and stimulus bundle between a scan controller, the truth table
// scanner and the 3-input circuit under test.
//   START, ABORT        : controller -> scanner (start a scan / abandon it)
//   A, B, C             : scanner -> circuit under test (vector bits 2..0)
//   Z                   : circuit under test -> scanner
//   BUSY, DONE          : scanner status (scan running / one-cycle completion)
//   TT, PASS, FAIL_IDX  : captured truth table and its verdict
// master = controller side, slave = scanner side.
interface truth_table_scanner_if;
  logic       START;
  logic       ABORT;
  logic       A;
  logic       B;
  logic       C;
  logic       Z;
  logic       BUSY;
  logic       DONE;
  logic [7:0] TT;
  logic       PASS;
  logic [2:0] FAIL_IDX;

  modport master (
    output START, ABORT, Z,
    input  A, B, C, BUSY, DONE, TT, PASS, FAIL_IDX
  );

  modport slave (
    input  START, ABORT, Z,
    output A, B, C, BUSY, DONE, TT, PASS, FAIL_IDX
  );
endinterface

// File: rtl/truth_table_scanner.sv
// Exhaustive truth-table scanner for a 3-input combinational circuit.
// Drives {A,B,C} through vectors 0..7, holding each for DWELL cycles, samples
// Z on the last cycle of each vector into TT[index], and on completion
// compares TT against EXPECTED, reporting PASS and the lowest mismatching
// vector index in FAIL_IDX.
// Ports:
//   CLK    : system clock, rising edge
//   RST_N  : asynchronous active-low reset
//   bus    : truth_table_scanner_if.slave (START/ABORT/Z in; A/B/C, BUSY,
//            DONE, TT, PASS, FAIL_IDX out)
// Parameters:
//   DWELL    : cycles each vector is held before Z is sampled (1..15)
//   EXPECTED : golden truth table, bit i = expected Z for vector i
module truth_table_scanner #(
  parameter int         DWELL    = 1,
  parameter logic [7:0] EXPECTED = 8'hB7
) (
  input logic                   CLK,
  input logic                   RST_N,
  truth_table_scanner_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(DWELL - 1);

  state_t     state;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic [2:0] vec;
  logic       busy;
  logic       done;
  logic [7:0] tt;
  logic       pass;
  logic [2:0] fail_idx;
  logic [7:0] tt_sampled;

  // Lowest set bit of the mismatch mask; 0 when there is no mismatch.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Table as it will look after the current vector's sample lands, so the
  // verdict on the last sample edge already includes bit 7.
  always_comb begin
    tt_sampled      = tt;
    tt_sampled[idx] = bus.Z;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      idx      <= 3'd0;
      cnt      <= 4'd0;
      vec      <= 3'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tt       <= 8'h00;
      pass     <= 1'b0;
      fail_idx <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.START) begin
            state    <= DRIVE;
            busy     <= 1'b1;
            idx      <= 3'd0;
            cnt      <= 4'd0;
            vec      <= 3'd0;
            tt       <= 8'h00;
            pass     <= 1'b0;
            fail_idx <= 3'd0;
          end
        end

        DRIVE: begin
          if (bus.ABORT) begin
            // Abort beats a coinciding sample edge; partial TT is kept.
            state    <= IDLE;
            busy     <= 1'b0;
            vec      <= 3'd0;
            idx      <= 3'd0;
            cnt      <= 4'd0;
            pass     <= 1'b0;
            fail_idx <= 3'd0;
          end else if (cnt == CNT_LAST) begin
            tt  <= tt_sampled;
            cnt <= 4'd0;
            if (idx != 3'd7) begin
              idx <= idx + 3'd1;
              vec <= idx + 3'd1;
            end else begin
              state    <= FINISH;
              busy     <= 1'b0;
              done     <= 1'b1;
              pass     <= (tt_sampled == EXPECTED);
              fail_idx <= lowest_set(tt_sampled ^ EXPECTED);
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        FINISH: begin
          // START is not looked at here; a held START restarts from IDLE.
          state <= IDLE;
          done  <= 1'b0;
          vec   <= 3'd0;
          idx   <= 3'd0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          vec   <= 3'd0;
        end
      endcase
    end
  end

  assign bus.A        = vec[2];
  assign bus.B        = vec[1];
  assign bus.C        = vec[0];
  assign bus.BUSY     = busy;
  assign bus.DONE     = done;
  assign bus.TT       = tt;
  assign bus.PASS     = pass;
  assign bus.FAIL_IDX = fail_idx;

endmodule

// File: tb/tb_truth_table_scanner.sv
module tb_truth_table_scanner;

  logic CLK;
  logic RST_N;
  int   checks;
  int   errors;
  int   mode1;   // circuit model attached to the DWELL=1 scanner
  int   mode3;   // circuit model attached to the DWELL=3 scanner

  truth_table_scanner_if if1();
  truth_table_scanner_if if3();

  // 0: correct circuit Z = (A&B) ^ ~(B&C); 1: stuck-at-0; 2: correct but 1 on vector 3
  function automatic logic cut(input int m, input logic a, input logic b, input logic c);
    logic z;
    z = (a & b) ^ ~(b & c);
    if (m == 1) z = 1'b0;
    if (m == 2 && {a, b, c} == 3'd3) z = 1'b1;
    return z;
  endfunction

  assign if1.Z = cut(mode1, if1.A, if1.B, if1.C);
  assign if3.Z = cut(mode3, if3.A, if3.B, if3.C);

  truth_table_scanner #(.DWELL(1), .EXPECTED(8'hB7)) dut1 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (if1.slave)
  );

  truth_table_scanner #(.DWELL(3), .EXPECTED(8'hB7)) dut3 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (if3.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Start edge on the DWELL=1 scanner; returns with START low, state DRIVE.
  task automatic pulse_start1();
    if1.START = 1'b1;
    tick();
    if1.START = 1'b0;
  endtask

  // Ticks until DONE on the DWELL=1 scanner; n = cycles after the start edge, -1 on timeout.
  task automatic wait_done1(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (if1.DONE === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    tick();
    tick();
    checks++;
    if ({if1.A, if1.B, if1.C, if1.BUSY, if1.DONE, if1.PASS} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl1 got %b want 000000", {if1.A, if1.B, if1.C, if1.BUSY, if1.DONE, if1.PASS});
    end
    checks++;
    if (if1.TT !== 8'h00 || if1.FAIL_IDX !== 3'd0) begin
      errors++;
      $display("FAIL reset_tt1 got tt=%h idx=%0d want 00/0", if1.TT, if1.FAIL_IDX);
    end
    checks++;
    if ({if3.A, if3.B, if3.C, if3.BUSY, if3.DONE, if3.PASS, if3.TT, if3.FAIL_IDX} !== 17'b0) begin
      errors++;
      $display("FAIL reset_all3 got %b want 0", {if3.A, if3.B, if3.C, if3.BUSY, if3.DONE, if3.PASS, if3.TT, if3.FAIL_IDX});
    end
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_pass_scan();
    mode1 = 0;
    pulse_start1();
    checks++;
    if (if1.BUSY !== 1'b1 || {if1.A, if1.B, if1.C} !== 3'd0) begin
      errors++;
      $display("FAIL pass_first busy=%b vec=%0d want 1/0", if1.BUSY, {if1.A, if1.B, if1.C});
    end
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if ({if1.A, if1.B, if1.C} !== 3'(k) || if1.DONE !== 1'b0) begin
        errors++;
        $display("FAIL pass_step%0d vec=%0d done=%b want %0d/0", k, {if1.A, if1.B, if1.C}, if1.DONE, k);
      end
    end
    tick();
    checks++;
    if (if1.DONE !== 1'b1 || if1.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL pass_done done=%b busy=%b want 1/0", if1.DONE, if1.BUSY);
    end
    checks++;
    if (if1.TT !== 8'hB7 || if1.PASS !== 1'b1 || if1.FAIL_IDX !== 3'd0) begin
      errors++;
      $display("FAIL pass_result tt=%h pass=%b idx=%0d want b7/1/0", if1.TT, if1.PASS, if1.FAIL_IDX);
    end
    tick();
    checks++;
    if (if1.DONE !== 1'b0 || {if1.A, if1.B, if1.C} !== 3'd0 || if1.TT !== 8'hB7 || if1.PASS !== 1'b1) begin
      errors++;
      $display("FAIL pass_hold done=%b vec=%0d tt=%h pass=%b want 0/0/b7/1", if1.DONE, {if1.A, if1.B, if1.C}, if1.TT, if1.PASS);
    end
  endtask

  task automatic test_stuck0();
    int n;
    mode1 = 1;
    pulse_start1();
    wait_done1(n);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL stuck0_latency got %0d want 8", n);
    end
    checks++;
    if (if1.TT !== 8'h00 || if1.PASS !== 1'b0 || if1.FAIL_IDX !== 3'd0) begin
      errors++;
      $display("FAIL stuck0_result tt=%h pass=%b idx=%0d want 00/0/0", if1.TT, if1.PASS, if1.FAIL_IDX);
    end
    tick();
  endtask

  task automatic test_vec3_fault();
    int n;
    mode1 = 2;
    pulse_start1();
    wait_done1(n);
    checks++;
    if (n !== 8) begin
      errors++;
      $display("FAIL vec3_latency got %0d want 8", n);
    end
    checks++;
    if (if1.TT !== 8'hBF || if1.PASS !== 1'b0 || if1.FAIL_IDX !== 3'd3) begin
      errors++;
      $display("FAIL vec3_result tt=%h pass=%b idx=%0d want bf/0/3", if1.TT, if1.PASS, if1.FAIL_IDX);
    end
    tick();
    mode1 = 0;
  endtask

  task automatic test_dwell3();
    int bad_vec;
    int bad_busy;
    mode3 = 0;
    bad_vec  = 0;
    bad_busy = 0;
    if3.START = 1'b1;
    tick();
    if3.START = 1'b0;
    // j = cycles since the start edge; vector j/3 is on the pins while j < 24
    for (int j = 0; j < 24; j++) begin
      if ({if3.A, if3.B, if3.C} !== 3'(j / 3)) bad_vec++;
      if (if3.BUSY !== 1'b1 || if3.DONE !== 1'b0) bad_busy++;
      if (j == 4) if3.START = 1'b1;   // lands on the cycle-5 edge, mid-scan
      if (j == 5) if3.START = 1'b0;
      tick();
    end
    checks++;
    if (bad_vec != 0) begin
      errors++;
      $display("FAIL dwell3_vectors got %0d bad cycles want 0", bad_vec);
    end
    checks++;
    if (bad_busy != 0) begin
      errors++;
      $display("FAIL dwell3_busy got %0d bad cycles want 0", bad_busy);
    end
    checks++;
    if (if3.DONE !== 1'b1 || if3.BUSY !== 1'b0 || if3.TT !== 8'hB7 || if3.PASS !== 1'b1) begin
      errors++;
      $display("FAIL dwell3_done done=%b busy=%b tt=%h pass=%b want 1/0/b7/1", if3.DONE, if3.BUSY, if3.TT, if3.PASS);
    end
    tick();
  endtask

  task automatic test_abort();
    int seen_done;
    int n;
    mode1 = 0;
    pulse_start1();
    for (int k = 0; k < 5; k++) tick();   // vectors 0..4 sampled, vector 5 on the pins
    checks++;
    if ({if1.A, if1.B, if1.C} !== 3'd5) begin
      errors++;
      $display("FAIL abort_setup vec=%0d want 5", {if1.A, if1.B, if1.C});
    end
    if1.ABORT = 1'b1;                     // coincides with vector 5's sample edge
    tick();
    if1.ABORT = 1'b0;
    checks++;
    if (if1.BUSY !== 1'b0 || if1.DONE !== 1'b0 || {if1.A, if1.B, if1.C} !== 3'd0 ||
        if1.TT !== 8'h17 || if1.PASS !== 1'b0 || if1.FAIL_IDX !== 3'd0) begin
      errors++;
      $display("FAIL abort_state busy=%b done=%b vec=%0d tt=%h pass=%b idx=%0d want 0/0/0/17/0/0",
               if1.BUSY, if1.DONE, {if1.A, if1.B, if1.C}, if1.TT, if1.PASS, if1.FAIL_IDX);
    end
    seen_done = 0;
    if1.ABORT = 1'b1;                     // ignored in IDLE
    for (int k = 0; k < 10; k++) begin
      tick();
      if (if1.DONE !== 1'b0 || if1.BUSY !== 1'b0) seen_done++;
    end
    if1.ABORT = 1'b0;
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL abort_nodone got %0d active cycles want 0", seen_done);
    end
    pulse_start1();
    wait_done1(n);
    checks++;
    if (n !== 8 || if1.TT !== 8'hB7 || if1.PASS !== 1'b1) begin
      errors++;
      $display("FAIL abort_rescan n=%0d tt=%h pass=%b want 8/b7/1", n, if1.TT, if1.PASS);
    end
    tick();
  endtask

  task automatic test_abort_on_sample();
    mode3 = 0;
    if3.START = 1'b1;
    tick();
    if3.START = 1'b0;
    for (int j = 0; j < 14; j++) tick();  // j=14: last cycle of vector 4
    if3.ABORT = 1'b1;
    tick();
    if3.ABORT = 1'b0;
    checks++;
    if (if3.BUSY !== 1'b0 || if3.DONE !== 1'b0 || if3.TT !== 8'h07 || {if3.A, if3.B, if3.C} !== 3'd0) begin
      errors++;
      $display("FAIL abort_sample3 busy=%b done=%b tt=%h vec=%0d want 0/0/07/0",
               if3.BUSY, if3.DONE, if3.TT, {if3.A, if3.B, if3.C});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    mode1 = 0;
    pulse_start1();
    for (int k = 0; k < 5; k++) tick();
    #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({if1.A, if1.B, if1.C, if1.BUSY, if1.DONE, if1.PASS} !== 6'b0 || if1.TT !== 8'h00 || if1.FAIL_IDX !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_async vec=%0d busy=%b done=%b tt=%h want all 0",
               {if1.A, if1.B, if1.C}, if1.BUSY, if1.DONE, if1.TT);
    end
    tick();
    RST_N = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (if1.DONE !== 1'b0 || if1.BUSY !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rstmid_nodone got %0d active cycles want 0", seen);
    end
    pulse_start1();
    wait_done1(n);
    checks++;
    if (n !== 8 || if1.TT !== 8'hB7 || if1.PASS !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_rescan n=%0d tt=%h pass=%b want 8/b7/1", n, if1.TT, if1.PASS);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    mode1 = 0;
    if1.START = 1'b1;
    tick();                               // first start edge
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (if1.DONE !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done1 got %b want 1", if1.DONE);
    end
    tick();                               // FINISH -> IDLE, START not taken here
    checks++;
    if (if1.BUSY !== 1'b0 || if1.DONE !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle busy=%b done=%b want 0/0", if1.BUSY, if1.DONE);
    end
    tick();                               // second start edge
    checks++;
    if (if1.BUSY !== 1'b1 || {if1.A, if1.B, if1.C} !== 3'd0 || if1.TT !== 8'h00 || if1.PASS !== 1'b0) begin
      errors++;
      $display("FAIL b2b_restart busy=%b vec=%0d tt=%h pass=%b want 1/0/00/0",
               if1.BUSY, {if1.A, if1.B, if1.C}, if1.TT, if1.PASS);
    end
    if1.START = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (if1.DONE !== 1'b1 || if1.TT !== 8'hB7) begin
      errors++;
      $display("FAIL b2b_done2 done=%b tt=%h want 1/b7", if1.DONE, if1.TT);
    end
    tick();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    mode1     = 0;
    mode3     = 0;
    RST_N     = 1'b1;
    if1.START = 1'b0;
    if1.ABORT = 1'b0;
    if3.START = 1'b0;
    if3.ABORT = 1'b0;
    #2;
    test_reset();
    test_pass_scan();
    test_stuck0();
    test_vec3_fault();
    test_dwell3();
    test_abort();
    test_abort_on_sample();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
